// File: rtl/l1_refill_arbiter_if.sv
// Miss/refill handshake bundle between the two L1 caches, the refill arbiter and the L2 port.
// The arbiter uses the slave view; caches/L2 (or a bench) use the master view.
interface l1_refill_arbiter_if #(
    parameter int unsigned address_width = 32,
    parameter int unsigned data_width    = 32,
    parameter int unsigned block_size    = 8
);
    localparam int unsigned line_addr_width =
        address_width - $clog2(data_width * block_size / 8);
    localparam int unsigned line_width_bits = block_size * data_width;

    logic                       I_ADDR_VALID;
    logic [line_addr_width-1:0] I_ADDR;
    logic [line_width_bits-1:0] I_DATA;
    logic                       I_DATA_VALID;

    logic                       D_ADDR_VALID;
    logic [line_addr_width-1:0] D_ADDR;
    logic [line_width_bits-1:0] D_DATA;
    logic                       D_DATA_VALID;

    logic                       L2_ADDR_VALID;
    logic [line_addr_width-1:0] L2_ADDR;
    logic                       L2_READY;
    logic [line_width_bits-1:0] L2_DATA;
    logic                       L2_DATA_VALID;
    logic                       L2_REQ_ID;

    logic                       BUSY;

    modport master (
        output I_ADDR_VALID, I_ADDR, D_ADDR_VALID, D_ADDR,
        output L2_READY, L2_DATA, L2_DATA_VALID,
        input  I_DATA, I_DATA_VALID, D_DATA, D_DATA_VALID,
        input  L2_ADDR_VALID, L2_ADDR, L2_REQ_ID, BUSY
    );

    modport slave (
        input  I_ADDR_VALID, I_ADDR, D_ADDR_VALID, D_ADDR,
        input  L2_READY, L2_DATA, L2_DATA_VALID,
        output I_DATA, I_DATA_VALID, D_DATA, D_DATA_VALID,
        output L2_ADDR_VALID, L2_ADDR, L2_REQ_ID, BUSY
    );
endinterface

// File: rtl/l1_refill_arbiter.sv
// Shares the single L2 refill port between icache and dcache: captures miss pulses,
// arbitrates round-robin, keeps one request outstanding and returns the line as a pulse.
module l1_refill_arbiter #(
    parameter int unsigned address_width = 32,
    parameter int unsigned data_width    = 32,
    parameter int unsigned block_size    = 8
) (
    input logic                CLK,
    input logic                RST,
    l1_refill_arbiter_if.slave bus
);
    localparam int unsigned line_addr_width =
        address_width - $clog2(data_width * block_size / 8);
    localparam int unsigned line_width_bits = block_size * data_width;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic ID_I = 1'b0;
    localparam logic ID_D = 1'b1;

    logic [1:0]                 state_q, state_d;
    logic                       pending_i_q, pending_i_d;
    logic                       pending_d_q, pending_d_d;
    logic [line_addr_width-1:0] addr_i_q, addr_i_d;
    logic [line_addr_width-1:0] addr_d_q, addr_d_d;
    logic                       last_grant_q, last_grant_d;
    logic                       req_id_q, req_id_d;
    logic [line_addr_width-1:0] l2_addr_q, l2_addr_d;
    logic [line_width_bits-1:0] i_data_q, i_data_d;
    logic [line_width_bits-1:0] d_data_q, d_data_d;
    logic                       i_valid_q, i_valid_d;
    logic                       d_valid_q, d_valid_d;

    logic complete;
    logic clear_i, clear_d;
    logic set_i, set_d;
    logic grant_id;

    // A pulse landing on the completion cycle of the same side re-arms it (set wins).
    always_comb begin
        complete = (state_q == WAIT) && bus.L2_DATA_VALID;
        clear_i  = complete && (req_id_q == ID_I);
        clear_d  = complete && (req_id_q == ID_D);
        set_i    = bus.I_ADDR_VALID && (!pending_i_q || clear_i);
        set_d    = bus.D_ADDR_VALID && (!pending_d_q || clear_d);
    end

    always_comb begin
        pending_i_d = pending_i_q;
        addr_i_d    = addr_i_q;
        if (set_i) begin
            pending_i_d = 1'b1;
            addr_i_d    = bus.I_ADDR;
        end else if (clear_i) begin
            pending_i_d = 1'b0;
        end

        pending_d_d = pending_d_q;
        addr_d_d    = addr_d_q;
        if (set_d) begin
            pending_d_d = 1'b1;
            addr_d_d    = bus.D_ADDR;
        end else if (clear_d) begin
            pending_d_d = 1'b0;
        end
    end

    // On a tie the side that was not served last wins.
    always_comb begin
        if (pending_i_q && pending_d_q) begin
            grant_id = ~last_grant_q;
        end else if (pending_d_q) begin
            grant_id = ID_D;
        end else begin
            grant_id = ID_I;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_id_d     = req_id_q;
        l2_addr_d    = l2_addr_q;
        last_grant_d = last_grant_q;
        i_data_d     = i_data_q;
        d_data_d     = d_data_q;
        i_valid_d    = 1'b0;
        d_valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pending_i_q || pending_d_q) begin
                    state_d   = ISSUE;
                    req_id_d  = grant_id;
                    l2_addr_d = (grant_id == ID_D) ? addr_d_q : addr_i_q;
                end
            end
            ISSUE: begin
                if (bus.L2_READY) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.L2_DATA_VALID) begin
                    state_d      = IDLE;
                    last_grant_d = req_id_q;
                    if (req_id_q == ID_D) begin
                        d_data_d  = bus.L2_DATA;
                        d_valid_d = 1'b1;
                    end else begin
                        i_data_d  = bus.L2_DATA;
                        i_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            pending_i_q  <= 1'b0;
            pending_d_q  <= 1'b0;
            addr_i_q     <= '0;
            addr_d_q     <= '0;
            last_grant_q <= ID_D;
            req_id_q     <= ID_I;
            l2_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            pending_i_q  <= pending_i_d;
            pending_d_q  <= pending_d_d;
            addr_i_q     <= addr_i_d;
            addr_d_q     <= addr_d_d;
            last_grant_q <= last_grant_d;
            req_id_q     <= req_id_d;
            l2_addr_q    <= l2_addr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            i_data_q  <= '0;
            d_data_q  <= '0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
        end else begin
            i_data_q  <= i_data_d;
            d_data_q  <= d_data_d;
            i_valid_q <= i_valid_d;
            d_valid_q <= d_valid_d;
        end
    end

    assign bus.I_DATA        = i_data_q;
    assign bus.I_DATA_VALID  = i_valid_q;
    assign bus.D_DATA        = d_data_q;
    assign bus.D_DATA_VALID  = d_valid_q;
    assign bus.L2_ADDR_VALID = (state_q == ISSUE);
    assign bus.L2_ADDR       = l2_addr_q;
    assign bus.L2_REQ_ID     = req_id_q;
    assign bus.BUSY          = (state_q != IDLE);
endmodule

// File: tb/tb_l1_refill_arbiter.sv
// Directed bench for l1_refill_arbiter: hand-timed miss/refill sequences with
// immediate-assertion checks after each clock edge.
module tb_l1_refill_arbiter;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    int total = 0;
    int bad   = 0;

    l1_refill_arbiter_if bus ();

    l1_refill_arbiter dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet(input string tag);
        check({tag, "_ivalid"}, bus.I_DATA_VALID, 0);
        check({tag, "_dvalid"}, bus.D_DATA_VALID, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, bus.BUSY, 0);
        check({tag, "_l2v"}, bus.L2_ADDR_VALID, 0);
        check({tag, "_l2a"}, bus.L2_ADDR, 0);
        check({tag, "_id"}, bus.L2_REQ_ID, 0);
        check({tag, "_idata"}, bus.I_DATA, 0);
        check({tag, "_ddata"}, bus.D_DATA, 0);
        quiet(tag);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    logic [255:0] line_a5;
    logic [255:0] line_x1;
    logic [255:0] line_x2;
    logic [255:0] line_x3;
    logic [255:0] line_rr;
    int           waited;
    int           exp_base;

    initial begin
        line_a5 = {32{8'hA5}};
        line_x1 = {8{32'h1111_0001}};
        line_x2 = {8{32'h2222_0002}};
        line_x3 = {8{32'h3333_0003}};

        bus.I_ADDR_VALID  = 1'b0;
        bus.I_ADDR        = '0;
        bus.D_ADDR_VALID  = 1'b0;
        bus.D_ADDR        = '0;
        bus.L2_READY      = 1'b0;
        bus.L2_DATA       = '0;
        bus.L2_DATA_VALID = 1'b0;

        tick();
        tick();
        check_reset_outputs("reset");
        RST = 1'b0;

        // Single I miss: pulse at t, request at t+2, data at t+10, pulse at t+11.
        bus.I_ADDR_VALID = 1'b1;
        bus.I_ADDR       = 27'h0000123;
        bus.L2_READY     = 1'b1;
        tick();
        bus.I_ADDR_VALID = 1'b0;
        check("single_t1_l2v", bus.L2_ADDR_VALID, 0);
        tick();
        check("single_l2v", bus.L2_ADDR_VALID, 1);
        check("single_l2a", bus.L2_ADDR, 27'h0000123);
        check("single_id", bus.L2_REQ_ID, 0);
        check("single_busy", bus.BUSY, 1);
        tick();
        check("single_wait_l2v", bus.L2_ADDR_VALID, 0);
        check("single_wait_busy", bus.BUSY, 1);
        for (int i = 0; i < 7; i++) begin
            quiet("single_wait");
            tick();
        end
        bus.L2_DATA_VALID = 1'b1;
        bus.L2_DATA       = line_a5;
        quiet("single_u");
        tick();
        bus.L2_DATA_VALID = 1'b0;
        check("single_ivalid", bus.I_DATA_VALID, 1);
        check("single_idata", bus.I_DATA, line_a5);
        check("single_dvalid", bus.D_DATA_VALID, 0);
        check("single_done_busy", bus.BUSY, 0);
        tick();
        check("single_pulse_end", bus.I_DATA_VALID, 0);
        check("single_idata_hold", bus.I_DATA, line_a5);
        check("single_no_req", bus.L2_ADDR_VALID, 0);

        // Simultaneous I/D miss after reset: I first, D queued behind it.
        do_reset();
        bus.I_ADDR_VALID = 1'b1;
        bus.I_ADDR       = 27'h10;
        bus.D_ADDR_VALID = 1'b1;
        bus.D_ADDR       = 27'h20;
        tick();
        bus.I_ADDR_VALID = 1'b0;
        bus.D_ADDR_VALID = 1'b0;
        tick();
        check("sim_first_l2a", bus.L2_ADDR, 27'h10);
        check("sim_first_id", bus.L2_REQ_ID, 0);
        check("sim_first_l2v", bus.L2_ADDR_VALID, 1);
        tick();
        bus.L2_DATA_VALID = 1'b1;
        bus.L2_DATA       = line_x1;
        tick();
        bus.L2_DATA_VALID = 1'b0;
        check("sim_ivalid", bus.I_DATA_VALID, 1);
        check("sim_idata", bus.I_DATA, line_x1);
        check("sim_gap_l2v", bus.L2_ADDR_VALID, 0);
        tick();
        check("sim_second_l2v", bus.L2_ADDR_VALID, 1);
        check("sim_second_l2a", bus.L2_ADDR, 27'h20);
        check("sim_second_id", bus.L2_REQ_ID, 1);
        tick();
        bus.L2_DATA_VALID = 1'b1;
        bus.L2_DATA       = line_x2;
        tick();
        bus.L2_DATA_VALID = 1'b0;
        check("sim_dvalid", bus.D_DATA_VALID, 1);
        check("sim_ddata", bus.D_DATA, line_x2);
        check("sim_ivalid_off", bus.I_DATA_VALID, 0);
        check("sim_idata_hold", bus.I_DATA, line_x1);

        // Round-robin: each side re-requests on its own completion cycle (set wins).
        do_reset();
        bus.I_ADDR_VALID = 1'b1;
        bus.I_ADDR       = 27'h100;
        bus.D_ADDR_VALID = 1'b1;
        bus.D_ADDR       = 27'h201;
        tick();
        bus.I_ADDR_VALID = 1'b0;
        bus.D_ADDR_VALID = 1'b0;
        for (int k = 0; k < 6; k++) begin
            waited = 0;
            while (!bus.L2_ADDR_VALID && waited < 20) begin
                tick();
                waited++;
            end
            exp_base = (k % 2 == 1) ? 32'h200 : 32'h100;
            check("rr_req_seen", bus.L2_ADDR_VALID, 1);
            check("rr_id", bus.L2_REQ_ID, k % 2);
            check("rr_addr", bus.L2_ADDR, exp_base + k);
            tick();
            line_rr           = {8{32'hC0DE_0000 + k}};
            bus.L2_DATA_VALID = 1'b1;
            bus.L2_DATA       = line_rr;
            if (k % 2 == 0) begin
                bus.I_ADDR_VALID = 1'b1;
                bus.I_ADDR       = 27'(exp_base + k + 2);
            end else begin
                bus.D_ADDR_VALID = 1'b1;
                bus.D_ADDR       = 27'(exp_base + k + 2);
            end
            tick();
            bus.L2_DATA_VALID = 1'b0;
            bus.I_ADDR_VALID  = 1'b0;
            bus.D_ADDR_VALID  = 1'b0;
            check("rr_ivalid", bus.I_DATA_VALID, (k % 2 == 0) ? 1 : 0);
            check("rr_dvalid", bus.D_DATA_VALID, (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 0) check("rr_idata", bus.I_DATA, line_rr);
            else            check("rr_ddata", bus.D_DATA, line_rr);
        end

        // Backpressure: request held stable while L2_READY is low, stray data ignored.
        do_reset();
        bus.L2_READY     = 1'b0;
        bus.D_ADDR_VALID = 1'b1;
        bus.D_ADDR       = 27'h77;
        tick();
        bus.D_ADDR_VALID = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_l2v", bus.L2_ADDR_VALID, 1);
            check("bp_l2a", bus.L2_ADDR, 27'h77);
            check("bp_id", bus.L2_REQ_ID, 1);
            quiet("bp_hold");
            bus.L2_DATA_VALID = (i == 2);
            bus.L2_DATA       = line_x1;
            tick();
        end
        bus.L2_DATA_VALID = 1'b0;
        check("bp_still_issue", bus.L2_ADDR_VALID, 1);
        check("bp_ddata_untouched", bus.D_DATA, 0);
        bus.L2_READY = 1'b1;
        tick();
        check("bp_wait_l2v", bus.L2_ADDR_VALID, 0);
        check("bp_wait_busy", bus.BUSY, 1);
        bus.L2_DATA_VALID = 1'b1;
        bus.L2_DATA       = line_x3;
        tick();
        bus.L2_DATA_VALID = 1'b0;
        check("bp_dvalid", bus.D_DATA_VALID, 1);
        check("bp_ddata", bus.D_DATA, line_x3);

        // Duplicate pulse while pending is dropped; stray L2 data in IDLE is ignored.
        bus.L2_READY     = 1'b0;
        bus.D_ADDR_VALID = 1'b1;
        bus.D_ADDR       = 27'h55;
        tick();
        bus.D_ADDR       = 27'h99;
        tick();
        bus.D_ADDR_VALID = 1'b0;
        check("dup_l2a", bus.L2_ADDR, 27'h55);
        tick();
        check("dup_l2a_hold", bus.L2_ADDR, 27'h55);
        bus.L2_READY = 1'b1;
        tick();
        bus.L2_DATA_VALID = 1'b1;
        bus.L2_DATA       = line_x2;
        tick();
        bus.L2_DATA_VALID = 1'b0;
        check("dup_dvalid", bus.D_DATA_VALID, 1);
        check("dup_ddata", bus.D_DATA, line_x2);
        tick();
        check("dup_not_requeued", bus.L2_ADDR_VALID, 0);
        check("dup_idle", bus.BUSY, 0);
        bus.L2_DATA_VALID = 1'b1;
        bus.L2_DATA       = line_a5;
        tick();
        bus.L2_DATA_VALID = 1'b0;
        quiet("stray");
        check("stray_ddata", bus.D_DATA, line_x2);
        check("stray_busy", bus.BUSY, 0);

        // Reset while waiting for data; a late L2_DATA_VALID must not complete anything.
        bus.I_ADDR_VALID = 1'b1;
        bus.I_ADDR       = 27'h3;
        tick();
        bus.I_ADDR_VALID = 1'b0;
        tick();
        tick();
        check("rst_in_wait_busy", bus.BUSY, 1);
        check("rst_in_wait_l2v", bus.L2_ADDR_VALID, 0);
        do_reset();
        check_reset_outputs("rst_mid");
        bus.L2_DATA_VALID = 1'b1;
        bus.L2_DATA       = line_x3;
        tick();
        bus.L2_DATA_VALID = 1'b0;
        check_reset_outputs("rst_late");
        tick();
        check("rst_no_req", bus.L2_ADDR_VALID, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
